// File: rtl/sys_bus_pkg.sv
// -----------------------------------------------------------------------------
// sys_bus_pkg
// Shared definitions for the system-bus decoder slice:
//   - response encodings, shared with the AXI4-Lite slave's bresp/rresp
//   - decoder FSM state encoding
//   - default sub-bus count and local address width
//   - sub-bus index extraction and response helpers
// -----------------------------------------------------------------------------
package sys_bus_pkg;

  localparam int unsigned SYS_SN_DEF = 8;
  localparam int unsigned SYS_SA_DEF = 20;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } sys_resp_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } dec_state_e;

  // Index field sits directly above the local address: addr[sa+iw-1:sa].
  function automatic logic [3:0] sys_bus_index(input logic [63:0] addr,
                                               input int unsigned sa,
                                               input int unsigned iw);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = addr >> sa;
    mask    = (64'd1 << iw) - 64'd1;
    return 4'(shifted & mask);
  endfunction

  function automatic sys_resp_e resp_from_err(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/sys_bus_decoder_if.sv
// -----------------------------------------------------------------------------
// sys_bus_decoder_if
// Bundles the upstream system-bus channel and the SN broadcast sub-buses.
//   slave  : decoder view (takes upstream requests, drives the sub-buses)
//   master : environment view (upstream requester plus the peripherals)
// Upstream : sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
//            sys_rdata_o, sys_err_o, sys_ack_o
// Sub-bus  : sub_addr_o, sub_wdata_o, sub_sel_o, sub_wen_o[SN], sub_ren_o[SN],
//            sub_rdata_i[SN*DW] (slave k at [k*DW +: DW]), sub_err_i, sub_ack_i
// -----------------------------------------------------------------------------
interface sys_bus_decoder_if
  import sys_bus_pkg::*;
#(
  parameter int unsigned SN = SYS_SN_DEF,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = DW / 8
);

  logic [AW-1:0]    sys_addr_i;
  logic [DW-1:0]    sys_wdata_i;
  logic [SW-1:0]    sys_sel_i;
  logic             sys_wen_i;
  logic             sys_ren_i;
  logic [DW-1:0]    sys_rdata_o;
  logic             sys_err_o;
  logic             sys_ack_o;

  logic [AW-1:0]    sub_addr_o;
  logic [DW-1:0]    sub_wdata_o;
  logic [SW-1:0]    sub_sel_o;
  logic [SN-1:0]    sub_wen_o;
  logic [SN-1:0]    sub_ren_o;
  logic [SN*DW-1:0] sub_rdata_i;
  logic [SN-1:0]    sub_err_i;
  logic [SN-1:0]    sub_ack_i;

  modport slave (
    input  sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    output sys_rdata_o, sys_err_o, sys_ack_o,
    output sub_addr_o, sub_wdata_o, sub_sel_o, sub_wen_o, sub_ren_o,
    input  sub_rdata_i, sub_err_i, sub_ack_i
  );

  modport master (
    output sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    input  sys_rdata_o, sys_err_o, sys_ack_o,
    input  sub_addr_o, sub_wdata_o, sub_sel_o, sub_wen_o, sub_ren_o,
    output sub_rdata_i, sub_err_i, sub_ack_i
  );

endinterface

// File: rtl/sys_bus_tmo.sv
// -----------------------------------------------------------------------------
// sys_bus_tmo
// Saturating timeout counter for one outstanding sub-bus access.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load 0 and arm (takes priority over clear)
//   clear      : disarm and return to 0
//   expired    : registered; high while armed and TMO cycles have been counted
// The counter sits at 0 in the first armed cycle, so expired rises in the
// TMO-th armed cycle and holds there until cleared.
// -----------------------------------------------------------------------------
module sys_bus_tmo #(
  parameter int unsigned TMO = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam logic [4:0] LIMIT = 5'(TMO - 1);

  logic [4:0] cnt_r;
  logic [4:0] cnt_s;
  logic       run_r;
  logic       run_s;
  logic       expired_r;

  // Next count: load, clear, count up while armed, or hold at the limit.
  always_comb begin
    cnt_s = cnt_r;
    run_s = run_r;
    if (start) begin
      cnt_s = 5'd0;
      run_s = 1'b1;
    end else if (clear) begin
      cnt_s = 5'd0;
      run_s = 1'b0;
    end else if (run_r && (cnt_r != LIMIT)) begin
      cnt_s = cnt_r + 5'd1;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Counter, armed flag and expired flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 5'd0;
      run_r     <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      run_r     <= run_s;
      expired_r <= run_s && (cnt_s == LIMIT);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/sys_bus_decoder.sv
// -----------------------------------------------------------------------------
// sys_bus_decoder
// Routes the single upstream system-bus access to one of SN sub-buses picked
// by sys_addr_i[SA+log2(SN)-1:SA]. One access is outstanding at a time.
//   sys_clk_i  : clock
//   sys_rstn_i : asynchronous active-low reset
//   bus        : sys_bus_decoder_if.slave (upstream channel + sub-buses)
// Unmapped indices (SLV_EN bit clear) answer ack+err one cycle after the
// strobe. A mapped peripheral that stays silent for TMO cycles gets the same
// error response; its late acknowledge is then dropped.
// -----------------------------------------------------------------------------
module sys_bus_decoder
  import sys_bus_pkg::*;
#(
  parameter int unsigned   SN     = SYS_SN_DEF,
  parameter int unsigned   AW     = 32,
  parameter int unsigned   DW     = 32,
  parameter int unsigned   SW     = DW / 8,
  parameter int unsigned   SA     = SYS_SA_DEF,
  parameter logic [SN-1:0] SLV_EN = {SN{1'b1}},
  parameter int unsigned   TMO    = 16
) (
  input logic              sys_clk_i,
  input logic              sys_rstn_i,
  sys_bus_decoder_if.slave bus
);

  localparam int unsigned IW = $clog2(SN);

  dec_state_e    state_r;
  dec_state_e    state_s;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_s;
  logic          wr_r;
  logic          wr_s;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] wdata_s;
  logic [SW-1:0] sel_r;
  logic [SW-1:0] sel_s;
  logic [SN-1:0] sub_wen_r;
  logic [SN-1:0] sub_wen_s;
  logic [SN-1:0] sub_ren_r;
  logic [SN-1:0] sub_ren_s;
  logic          ack_r;
  logic          ack_s;
  logic          err_r;
  logic          err_s;
  logic [DW-1:0] rdata_r;
  logic [DW-1:0] rdata_s;
  sys_resp_e     resp_s;

  logic [IW-1:0] req_idx_s;
  logic          req_mapped_s;
  logic [SN-1:0] req_onehot_s;
  logic [AW-1:0] req_local_s;
  logic          tgt_ack_s;
  logic          tgt_err_s;
  logic [DW-1:0] tgt_rdata_s;
  logic          tmo_start_s;
  logic          tmo_clear_s;
  logic          tmo_expired_s;
  logic [DW-1:0] rdata_arr_s [SN];

  for (genvar k = 0; k < SN; k++) begin : g_rdata
    assign rdata_arr_s[k] = bus.sub_rdata_i[k*DW +: DW];
  end

  // Request decode is only meaningful while idle; the latched index is used in PEND.
  assign req_idx_s    = IW'(sys_bus_index(64'(bus.sys_addr_i), SA, IW));
  assign req_mapped_s = SLV_EN[req_idx_s];
  assign req_onehot_s = {{(SN-1){1'b0}}, 1'b1} << req_idx_s;
  assign req_local_s  = AW'(bus.sys_addr_i[SA-1:0]);

  // Only the latched target is observed; acks from other indices never matter.
  assign tgt_ack_s   = bus.sub_ack_i[idx_r];
  assign tgt_err_s   = bus.sub_err_i[idx_r];
  assign tgt_rdata_s = rdata_arr_s[idx_r];

  sys_bus_tmo #(
    .TMO (TMO)
  ) u_tmo (
    .clk     (sys_clk_i),
    .rst_n   (sys_rstn_i),
    .start   (tmo_start_s),
    .clear   (tmo_clear_s),
    .expired (tmo_expired_s)
  );

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    wr_s        = wr_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    sel_s       = sel_r;
    sub_wen_s   = '0;
    sub_ren_s   = '0;
    ack_s       = 1'b0;
    rdata_s     = rdata_r;
    resp_s      = RESP_OKAY;
    tmo_start_s = 1'b0;
    tmo_clear_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.sys_wen_i || bus.sys_ren_i) begin
          // Write wins when both strobes arrive together.
          idx_s   = req_idx_s;
          wr_s    = bus.sys_wen_i;
          addr_s  = req_local_s;
          wdata_s = bus.sys_wdata_i;
          sel_s   = bus.sys_sel_i;
          if (req_mapped_s) begin
            if (bus.sys_wen_i) begin
              sub_wen_s = req_onehot_s;
            end else begin
              sub_ren_s = req_onehot_s;
            end
            tmo_start_s = 1'b1;
            state_s     = ST_PEND;
          end else begin
            ack_s   = 1'b1;
            resp_s  = RESP_SLVERR;
            rdata_s = '0;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_PEND: begin
        // An ack in the last counted cycle still beats the timeout.
        if (tgt_ack_s) begin
          ack_s       = 1'b1;
          resp_s      = resp_from_err(tgt_err_s);
          rdata_s     = wr_r ? '0 : tgt_rdata_s;
          tmo_clear_s = 1'b1;
          state_s     = ST_IDLE;
        end else if (tmo_expired_s) begin
          ack_s       = 1'b1;
          resp_s      = RESP_SLVERR;
          rdata_s     = '0;
          tmo_clear_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_PEND;
        end
      end

      default: begin
        tmo_clear_s = 1'b1;
        state_s     = ST_IDLE;
      end
    endcase

    err_s = ack_s && (resp_s == RESP_SLVERR);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      wr_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      sel_r     <= '0;
      sub_wen_r <= '0;
      sub_ren_r <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      wr_r      <= wr_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      sel_r     <= sel_s;
      sub_wen_r <= sub_wen_s;
      sub_ren_r <= sub_ren_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
      rdata_r   <= rdata_s;
    end
  end

  assign bus.sys_ack_o   = ack_r;
  assign bus.sys_err_o   = err_r;
  assign bus.sys_rdata_o = rdata_r;
  assign bus.sub_addr_o  = addr_r;
  assign bus.sub_wdata_o = wdata_r;
  assign bus.sub_sel_o   = sel_r;
  assign bus.sub_wen_o   = sub_wen_r;
  assign bus.sub_ren_o   = sub_ren_r;

endmodule

// File: tb/tb_sys_bus_decoder.sv
// -----------------------------------------------------------------------------
// tb_sys_bus_decoder
// Drives upstream accesses and peripheral responses, and predicts every
// output per cycle from the access rules: sub strobe one cycle after the
// request, response one cycle after the target ack or after TMO silent cycles,
// immediate error for unmapped indices, read data held between responses.
// -----------------------------------------------------------------------------
module tb_sys_bus_decoder;

  localparam int SN  = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int SA  = 20;
  localparam int TMO = 16;
  localparam logic [7:0] SLV_EN_TB = 8'h7F;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [DW-1:0] last_rdata = 32'h0;

  sys_bus_decoder_if #(.SN(SN), .AW(AW), .DW(DW), .SW(SW)) bus ();

  sys_bus_decoder #(
    .SN(SN), .AW(AW), .DW(DW), .SW(SW), .SA(SA), .SLV_EN(SLV_EN_TB), .TMO(TMO)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ack"},   64'(bus.sys_ack_o),   64'h0);
    check_val({tag, "_err"},   64'(bus.sys_err_o),   64'h0);
    check_val({tag, "_rdata"}, 64'(bus.sys_rdata_o), 64'h0);
    check_val({tag, "_wen"},   64'(bus.sub_wen_o),   64'h0);
    check_val({tag, "_ren"},   64'(bus.sub_ren_o),   64'h0);
    check_val({tag, "_addr"},  64'(bus.sub_addr_o),  64'h0);
    check_val({tag, "_wdata"}, 64'(bus.sub_wdata_o), 64'h0);
    check_val({tag, "_sel"},   64'(bus.sub_sel_o),   64'h0);
  endtask

  // Called just after a falling edge. d = PEND cycle (0 = strobe cycle) in
  // which the target acks; gap = extra idle cycles observed after the response.
  task automatic run_txn(input logic wen, input logic ren, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel, input int d,
                         input logic perr, input logic [31:0] prdata,
                         input logic noise, input int gap);
    int          idx;
    logic        mapped;
    logic        wr;
    int          exp_c;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [7:0]  onehot;
    logic [7:0]  ack_v;
    idx      = int'(addr[22:20]);
    mapped   = SLV_EN_TB[idx];
    wr       = wen;
    onehot   = 8'd1 << idx;
    exp_addr = addr & 32'h000F_FFFF;
    if (!mapped) begin
      exp_c = 1; exp_err = 1'b1; exp_rdata = 32'h0;
    end else if (d < TMO) begin
      exp_c = d + 2; exp_err = perr; exp_rdata = wr ? 32'h0 : prdata;
    end else begin
      exp_c = TMO + 1; exp_err = 1'b1; exp_rdata = 32'h0;
    end

    bus.sys_addr_i  = addr;
    bus.sys_wdata_i = wdata;
    bus.sys_sel_i   = sel;
    bus.sys_wen_i   = wen;
    bus.sys_ren_i   = ren;
    bus.sub_ack_i   = 8'h00;

    for (int c = 1; c <= exp_c + gap; c++) begin
      @(negedge clk);
      check_val("sys_ack",   64'(bus.sys_ack_o), 64'(c == exp_c));
      check_val("sys_err",   64'(bus.sys_err_o), (c == exp_c) ? 64'(exp_err) : 64'h0);
      check_val("sys_rdata", 64'(bus.sys_rdata_o), (c >= exp_c) ? 64'(exp_rdata) : 64'(last_rdata));
      check_val("sub_wen",   64'(bus.sub_wen_o), (c == 1 && mapped && wr)  ? 64'(onehot) : 64'h0);
      check_val("sub_ren",   64'(bus.sub_ren_o), (c == 1 && mapped && !wr) ? 64'(onehot) : 64'h0);
      check_val("sub_addr",  64'(bus.sub_addr_o),  64'(exp_addr));
      check_val("sub_wdata", 64'(bus.sub_wdata_o), 64'(wdata));
      check_val("sub_sel",   64'(bus.sub_sel_o),   64'(sel));

      bus.sys_wen_i = 1'b0;
      bus.sys_ren_i = 1'b0;
      if (noise && c < exp_c) begin
        // Upstream strobes while busy must be ignored.
        bus.sys_wen_i   = ($urandom_range(0, 3) == 0);
        bus.sys_ren_i   = ($urandom_range(0, 3) == 0);
        bus.sys_addr_i  = $urandom;
        bus.sys_wdata_i = $urandom;
        bus.sys_sel_i   = 4'($urandom);
      end
      for (int k = 0; k < SN; k++) bus.sub_rdata_i[k*DW +: DW] = $urandom;
      bus.sub_err_i = 8'($urandom);
      ack_v = noise ? 8'($urandom) : 8'h00;
      if (c < exp_c) ack_v = ack_v & ~onehot;
      if (mapped && (c - 1) == d) begin
        ack_v = ack_v | onehot;
        bus.sub_err_i[idx] = perr;
        bus.sub_rdata_i[idx*DW +: DW] = prdata;
      end
      bus.sub_ack_i = ack_v;
    end
    last_rdata = exp_rdata;
  endtask

  initial begin
    int mode;
    int d;
    logic [31:0] addr;
    bus.sys_addr_i  = 32'h0;
    bus.sys_wdata_i = 32'h0;
    bus.sys_sel_i   = 4'h0;
    bus.sys_wen_i   = 1'b0;
    bus.sys_ren_i   = 1'b0;
    bus.sub_rdata_i = '0;
    bus.sub_err_i   = 8'h00;
    bus.sub_ack_i   = 8'h00;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Write to sub 3, ack one cycle after the strobe.
    run_txn(1'b1, 1'b0, 32'h0030_0008, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 32'h0, 1'b0, 1);
    // Read from sub 1 with a combinational ack.
    run_txn(1'b0, 1'b1, 32'h0010_0004, 32'h0, 4'hF, 0, 1'b0, 32'h1234_5678, 1'b0, 1);
    // Unmapped index 7.
    run_txn(1'b0, 1'b1, 32'h0070_0000, 32'h0, 4'h3, 0, 1'b0, 32'h0, 1'b0, 1);
    // Silent sub 2 times out; its ack at T+20 is dropped.
    run_txn(1'b0, 1'b1, 32'h0020_0000, 32'h0, 4'hF, 19, 1'b0, 32'hCAFE_F00D, 1'b0, 4);
    // Ack in the last counted PEND cycle still wins, with slave error.
    run_txn(1'b0, 1'b1, 32'h0010_0100, 32'h0, 4'h1, TMO - 1, 1'b1, 32'hA5A5_5A5A, 1'b0, 0);
    // Both strobes to index 5: write only; busy-time strobes and foreign acks ignored.
    run_txn(1'b1, 1'b1, 32'h0050_0010, 32'h0BAD_CAFE, 4'hC, 3, 1'b0, 32'h0, 1'b1, 2);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      d    = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 6);
      addr = $urandom;
      run_txn(mode != 1, mode != 0, addr, $urandom, 4'($urandom), d, 1'($urandom),
              $urandom, 1'($urandom), $urandom_range(0, 3));
    end

    // Reset while an access to index 2 is pending.
    run_txn(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'hF, 1, 1'b0, 32'h7777_1111, 1'b0, 0);
    bus.sys_addr_i = 32'h0020_0ABC;
    bus.sys_ren_i  = 1'b1;
    @(negedge clk);
    bus.sys_ren_i  = 1'b0;
    bus.sub_ack_i  = 8'h00;
    repeat (3) @(negedge clk);
    check_val("pre_rst_addr", 64'(bus.sub_addr_o), 64'h0000_0ABC);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    check_val("rst_hold_ack", 64'(bus.sys_ack_o), 64'h0);
    rst_n      = 1'b1;
    last_rdata = 32'h0;
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'hF, 2, 1'b0, 32'h0F0F_1234, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
